bnn_layer_sequencer: RTL and testbench

//  Sequences a chain of NUM_LAYERS BNN layer engines for one inference at a time.
//  - Accepts an input vector via valid/ready and registers it for layer 0.
//  - Holds each layer in clear until its predecessor signals done, then releases it.
//  - Captures the last layer's result and presents it on a valid/ready output.
//  - Reports a per-layer timeout and the latency of the last inference.

---
 rtl/bnn_layer_sequencer.sv | 131 +++++++++++++
 tb/tb_bnn_layer_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/bnn_layer_sequencer.sv
// Runs one inference at a time through a chain of BNN layer engines: each layer is
// held in clear until its predecessor is done, and the last layer's result is captured.
module bnn_layer_sequencer #(
    parameter int NUM_LAYERS = 2,
    parameter int IN_WIDTH   = 512,
    parameter int OUT_WIDTH  = 64,
    parameter int TIMEOUT    = 4096,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_WIDTH-1:0]   in_data,
    output logic [IN_WIDTH-1:0]   in_buf,
    output logic [NUM_LAYERS-1:0] layer_clr,
    input  logic [NUM_LAYERS-1:0] layer_done,
    input  logic [OUT_WIDTH-1:0]  final_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic                  busy,
    output logic                  err_timeout,
    output logic [CNT_WIDTH-1:0]  cycles_last
);
    localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int TMR_W = $clog2(TIMEOUT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LAYERS - 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;

    state_t                state, state_n;
    logic [IDX_W-1:0]      idx, idx_n;
    logic [TMR_W-1:0]      timer, timer_n;
    logic [CNT_WIDTH-1:0]  lat, lat_n, lat_inc;
    logic [IN_WIDTH-1:0]   in_buf_n;
    logic [OUT_WIDTH-1:0]  out_data_n;
    logic                  out_valid_n, err_n;
    logic [CNT_WIDTH-1:0]  cycles_n;
    logic [NUM_LAYERS-1:0] clr_n;

    assign lat_inc = (lat == '1) ? lat : lat + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            timer       <= '0;
            lat         <= '0;
            in_buf      <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            err_timeout <= 1'b0;
            cycles_last <= '0;
            layer_clr   <= '1;
            in_ready    <= 1'b1;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            timer       <= timer_n;
            lat         <= lat_n;
            in_buf      <= in_buf_n;
            out_data    <= out_data_n;
            out_valid   <= out_valid_n;
            err_timeout <= err_n;
            cycles_last <= cycles_n;
            layer_clr   <= clr_n;
            // Handshake flags are registered from the next state so they align with it.
            in_ready    <= (state_n == IDLE);
            busy        <= (state_n != IDLE);
        end
    end

    always_comb begin
        state_n     = state;
        idx_n       = idx;
        timer_n     = timer;
        lat_n       = lat;
        in_buf_n    = in_buf;
        out_data_n  = out_data;
        out_valid_n = out_valid;
        err_n       = err_timeout;
        cycles_n    = cycles_last;
        clr_n       = layer_clr;
        case (state)
            IDLE: begin
                clr_n = '1;
                if (in_valid) begin
                    in_buf_n = in_data;
                    idx_n    = '0;
                    clr_n[0] = 1'b0;
                    err_n    = 1'b0;
                    timer_n  = '0;
                    lat_n    = '0;
                    state_n  = RUN;
                end
            end
            RUN: begin
                timer_n = timer + 1'b1;
                lat_n   = lat_inc;
                // A done in the timeout cycle still completes the layer.
                if (layer_done[idx]) begin
                    if (idx != LAST_IDX) begin
                        idx_n        = idx + 1'b1;
                        clr_n[idx_n] = 1'b0;
                        timer_n      = '0;
                    end else begin
                        out_data_n  = final_out;
                        out_valid_n = 1'b1;
                        cycles_n    = lat_inc;
                        state_n     = OUT;
                    end
                end else if (timer == TMR_MAX) begin
                    err_n   = 1'b1;
                    clr_n   = '1;
                    state_n = IDLE;
                end
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_n = 1'b0;
                    clr_n       = '1;
                    state_n     = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_bnn_layer_sequencer.sv
// Bench for bnn_layer_sequencer: stub layers report done a programmable number of cycles
// after their clear drops; expected results go through a scoreboard queue.
module tb_bnn_layer_sequencer;
    localparam int NL = 2, IW = 512, OW = 64, TO = 20, CW = 16;
    localparam logic [OW-1:0] KEY = 64'hC3C3_5A5A_0F0F_9696;

    logic          clk = 1'b0, reset = 1'b1;
    logic          in_valid = 1'b0, in_ready;
    logic [IW-1:0] in_data = '0, in_buf;
    logic [NL-1:0] layer_clr, layer_done;
    logic [OW-1:0] final_out, out_data;
    logic          out_valid, out_ready = 1'b0;
    logic          busy, err_timeout;
    logic [CW-1:0] cycles_last;

    int checks = 0, failures = 0;
    int cyc = 0;
    int cnt [NL];
    int dly [NL];
    bit force1 = 1'b0;
    logic [OW-1:0] exp_q [$];
    logic [OW-1:0] exp_v;
    int acc;

    bnn_layer_sequencer #(.NUM_LAYERS(NL), .IN_WIDTH(IW), .OUT_WIDTH(OW),
                          .TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_buf(in_buf), .layer_clr(layer_clr),
        .layer_done(layer_done), .final_out(final_out), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .busy(busy),
        .err_timeout(err_timeout), .cycles_last(cycles_last));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stub layer j: done is sampled by the sequencer dly[j] edges after its clear drops; 0 = never.
    always @(posedge clk)
        for (int j = 0; j < NL; j++)
            cnt[j] <= layer_clr[j] ? 0 : ((cnt[j] < 1000) ? cnt[j] + 1 : cnt[j]);

    always_comb begin
        layer_done = '0;
        for (int j = 0; j < NL; j++)
            if (!layer_clr[j] && dly[j] != 0 && cnt[j] >= dly[j] - 1) layer_done[j] = 1'b1;
        if (force1) layer_done[1] = 1'b1;
    end

    assign final_out = in_buf[OW-1:0] ^ KEY;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // One-cycle accept from IDLE; acc holds the accept edge number.
    task automatic start(input logic [IW-1:0] v, input bit push);
        in_valid = 1'b1;
        in_data  = v;
        if (push) exp_q.push_back(v[OW-1:0] ^ KEY);
        tick();
        acc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic pop_exp(output logic [OW-1:0] e);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++; if (layer_clr !== 2'b11) begin failures++; $display("FAIL reset_clr got=%b exp=11", layer_clr); end
        checks++; if (in_buf !== '0 || out_data !== '0) begin failures++; $display("FAIL reset_data in_buf/out_data not zero"); end
        checks++; if ({out_valid, err_timeout, busy, in_ready} !== 4'b0001) begin failures++; $display("FAIL reset_flags got=%b exp=0001", {out_valid, err_timeout, busy, in_ready}); end
        checks++; if (cycles_last !== '0) begin failures++; $display("FAIL reset_cycles got=%0d exp=0", cycles_last); end
        #2 reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [1:0] ec;
        int n;
        dly[0] = 9; dly[1] = 3; out_ready = 1'b1;
        start({64{8'hA5}}, 1'b1);
        for (n = 0; n <= 13; n++) begin
            ec = (n < 9) ? 2'b10 : (n < 13) ? 2'b00 : 2'b11;
            checks++; if (layer_clr !== ec) begin failures++; $display("FAIL basic_clr n=%0d got=%b exp=%b", n, layer_clr, ec); end
            checks++; if (out_valid !== (n == 12)) begin failures++; $display("FAIL basic_valid n=%0d got=%b", n, out_valid); end
            if (n == 12) begin
                pop_exp(exp_v);
                checks++; if (out_data !== exp_v) begin failures++; $display("FAIL basic_data got=%h exp=%h", out_data, exp_v); end
                checks++; if (cycles_last !== 16'd12) begin failures++; $display("FAIL basic_cycles got=%0d exp=12", cycles_last); end
                checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL basic_err got=%b exp=0", err_timeout); end
            end
            if (n < 13) tick();
        end
        checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL basic_idle busy=%b in_ready=%b", busy, in_ready); end
    endtask

    task automatic test_backpressure();
        int b;
        dly[0] = 2; dly[1] = 2; out_ready = 1'b0;
        start({16{32'h1234_5678}}, 1'b1);
        for (b = 0; b < 40 && !out_valid; b++) tick();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_timeout no out_valid within 40 cycles"); end
        checks++; if (cycles_last !== 16'd4) begin failures++; $display("FAIL bp_cycles got=%0d exp=4", cycles_last); end
        exp_v = (exp_q.size() > 0) ? exp_q[0] : 'x;
        for (int i = 0; i < 5; i++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== exp_v || in_ready !== 1'b0) begin
                failures++; $display("FAIL bp_hold i=%0d valid=%b data=%h exp=%h in_ready=%b", i, out_valid, out_data, exp_v, in_ready);
            end
            tick();
        end
        out_ready = 1'b1;
        checks++; if (out_data !== exp_v) begin failures++; $display("FAIL bp_data got=%h exp=%h", out_data, exp_v); end
        pop_exp(exp_v);
        tick();
        checks++; if ({busy, in_ready, out_valid} !== 3'b010) begin failures++; $display("FAIL bp_idle got=%b exp=010", {busy, in_ready, out_valid}); end
    endtask

    task automatic test_timeout();
        int t1, b;
        bit seen_valid = 1'b0;
        dly[0] = 2; dly[1] = 0; out_ready = 1'b1;
        start({8{64'hFEED_0000_BEEF_0001}}, 1'b0);
        for (b = 0; b < 40 && layer_clr !== 2'b00; b++) tick();
        t1 = cyc;
        for (b = 0; b < 40 && !err_timeout; b++) begin
            tick();
            if (out_valid) seen_valid = 1'b1;
        end
        checks++; if (err_timeout !== 1'b1 || cyc - t1 != TO) begin failures++; $display("FAIL to_time got=%0d cycles exp=%0d err=%b", cyc - t1, TO, err_timeout); end
        checks++; if (layer_clr !== 2'b11 || busy !== 1'b0) begin failures++; $display("FAIL to_clr got=%b busy=%b exp=11/0", layer_clr, busy); end
        checks++; if (seen_valid) begin failures++; $display("FAIL to_valid out_valid rose on timeout run"); end
        tick();
        dly[1] = 3;
        start({8{64'h0BAD_F00D_CAFE_7777}}, 1'b1);
        checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL to_clear got=%b exp=0", err_timeout); end
        for (b = 0; b < 40 && !out_valid; b++) tick();
        pop_exp(exp_v);
        checks++; if (out_valid !== 1'b1 || out_data !== exp_v) begin failures++; $display("FAIL to_next got=%h exp=%h", out_data, exp_v); end
        tick();
    endtask

    task automatic test_ignore_done();
        int b;
        dly[0] = 6; dly[1] = 3; out_ready = 1'b1; force1 = 1'b1;
        start({16{32'h0F1E_2D3C}}, 1'b1);
        for (b = 0; b < 40 && layer_clr !== 2'b00; b++) begin
            checks++; if (layer_clr[1] !== 1'b1) begin failures++; $display("FAIL ign_clr1 n=%0d got=%b exp=1", cyc - acc, layer_clr[1]); end
            tick();
        end
        force1 = 1'b0;
        checks++; if (cyc - acc != 6) begin failures++; $display("FAIL ign_release got=%0d exp=6", cyc - acc); end
        for (b = 0; b < 40 && !out_valid; b++) tick();
        pop_exp(exp_v);
        checks++; if (out_data !== exp_v || cycles_last !== 16'd9) begin failures++; $display("FAIL ign_out data=%h exp=%h cycles=%0d exp=9", out_data, exp_v, cycles_last); end
        tick();
    endtask

    task automatic test_reset_mid();
        int b;
        dly[0] = 2; dly[1] = 0; out_ready = 1'b0;
        start({16{32'h7777_AAAA}}, 1'b0);
        for (b = 0; b < 40 && layer_clr !== 2'b00; b++) tick();
        tick();
        reset = 1'b1;
        tick();
        checks++; if ({layer_clr, busy, out_valid, in_ready} !== 5'b11001) begin
            failures++; $display("FAIL rst_mid got=%b exp=11001", {layer_clr, busy, out_valid, in_ready});
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [IW-1:0] v1, v2, prev;
        int outs = 0, changes = 0, t_out = 0, t_acc2 = 0;
        v1 = {8{64'h1111_2222_3333_4444}};
        v2 = {8{64'h9999_8888_7777_6666}};
        dly[0] = 2; dly[1] = 2; out_ready = 1'b1;
        in_valid = 1'b1; in_data = v1; exp_q.push_back(v1[OW-1:0] ^ KEY);
        tick();
        checks++; if (in_buf !== v1 || busy !== 1'b1) begin failures++; $display("FAIL b2b_first in_buf/busy wrong busy=%b", busy); end
        in_data = v2; exp_q.push_back(v2[OW-1:0] ^ KEY);
        prev = in_buf;
        for (int b = 0; b < 80 && outs < 2; b++) begin
            tick();
            if (in_buf !== prev) begin changes++; t_acc2 = cyc; prev = in_buf; in_valid = 1'b0; end
            if (out_valid) begin
                outs++;
                if (outs == 1) t_out = cyc;
                pop_exp(exp_v);
                checks++; if (out_data !== exp_v) begin failures++; $display("FAIL b2b_data k=%0d got=%h exp=%h", outs, out_data, exp_v); end
            end
        end
        in_valid = 1'b0;
        checks++; if (outs != 2 || changes != 1) begin failures++; $display("FAIL b2b_count outs=%0d exp=2 changes=%0d exp=1", outs, changes); end
        checks++; if (t_acc2 - t_out != 2 || prev !== v2) begin failures++; $display("FAIL b2b_accept gap=%0d exp=2", t_acc2 - t_out); end
        tick();
    endtask

    initial begin
        dly[0] = 0; dly[1] = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_timeout();
        test_ignore_done();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
